// File: rtl/mii_pkg.sv
// Shared types and defaults for the MII receive pattern checker.
package mii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_DATA = 2'd0,
    CLS_CTRL = 2'd1,
    CLS_ERR  = 2'd2,
    CLS_BAD  = 2'd3
  } lane_class_t;

  localparam logic [7:0] DEF_DATA_CHAR = 8'hAA;
  localparam logic [7:0] DEF_CTRL_CHAR = 8'h55;

  // ERR and BAD lanes both mark a cycle as errored and show up in lane_err.
  function automatic logic cls_is_fault(input lane_class_t c);
    return (c == CLS_ERR) || (c == CLS_BAD);
  endfunction

endpackage

// File: rtl/mii_lane_classify.sv
// Combinational classifier for one MII lane: byte plus control flag in, class out.
module mii_lane_classify
  import mii_pkg::*;
#(
  parameter logic [7:0] DATA_CHAR = DEF_DATA_CHAR,
  parameter logic [7:0] CTRL_CHAR = DEF_CTRL_CHAR
) (
  input  logic [7:0]  i_byte,
  input  logic        i_ctrl,
  output lane_class_t o_class
);

  // NOTE: assign a default before any branch so no path leaves o_class unassigned (no latch).
  always_comb begin
    o_class = CLS_BAD;
    if (i_ctrl) begin
      if (i_byte == CTRL_CHAR) o_class = CLS_CTRL;
    end else if (i_byte == DATA_CHAR) begin
      o_class = CLS_DATA;
    end else if (i_byte == ~DATA_CHAR) begin
      o_class = CLS_ERR;
    end
  end

endmodule

// File: rtl/mii_rx_checker.sv
// MII receive checker: per-lane class statistics, error mask and fault FSM.
// Define MII_RX_CHECKER_TXER_CHECK_EN to build the tx_er consistency counter.
module mii_rx_checker
  import mii_pkg::*;
#(
  parameter int         DATA_WIDTH        = 64,
  parameter logic [7:0] DATA_CHAR_PATTERN = DEF_DATA_CHAR,
  parameter logic [7:0] CTRL_CHAR_PATTERN = DEF_CTRL_CHAR,
  parameter int         COUNT_WIDTH       = 32,
  parameter int         ERR_THRESHOLD     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_WIDTH/8-1:0]    ctrl_in,
  input  logic                       tx_en,
  input  logic                       tx_er,
  input  logic                       clr,
  output logic [COUNT_WIDTH-1:0]     data_cnt,
  output logic [COUNT_WIDTH-1:0]     ctrl_cnt,
  output logic [COUNT_WIDTH-1:0]     err_cnt,
  output logic [COUNT_WIDTH-1:0]     bad_cnt,
  output logic [COUNT_WIDTH-1:0]     txer_mismatch_cnt,
  output logic [DATA_WIDTH/8-1:0]    lane_err,
  output logic [1:0]                 state,
  output logic                       fault
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int CONS_W = $clog2(ERR_THRESHOLD + 1);

  lane_class_t            w_class [LANES];
  logic [CNT_W-1:0]       w_n_data, w_n_ctrl, w_n_err, w_n_bad;
  logic [LANES-1:0]       w_err_mask;
  logic                   w_errored;
  logic [CONS_W-1:0]      w_consec_inc;
  logic                   w_hit;

  logic [COUNT_WIDTH-1:0] r_data_cnt, r_ctrl_cnt, r_err_cnt, r_bad_cnt;
  logic [LANES-1:0]       r_lane_err;
  logic [CONS_W-1:0]      r_consec;
  state_t                 r_state;
  logic                   r_fault;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mii_lane_classify #(
      .DATA_CHAR (DATA_CHAR_PATTERN),
      .CTRL_CHAR (CTRL_CHAR_PATTERN)
    ) u_classify (
      .i_byte  (data_in[8*g +: 8]),
      .i_ctrl  (ctrl_in[g]),
      .o_class (w_class[g])
    );
  end

  always_comb begin
    w_n_data   = '0;
    w_n_ctrl   = '0;
    w_n_err    = '0;
    w_n_bad    = '0;
    w_err_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_err_mask[i] = cls_is_fault(w_class[i]);
      case (w_class[i])
        CLS_DATA: w_n_data = w_n_data + CNT_W'(1);
        CLS_CTRL: w_n_ctrl = w_n_ctrl + CNT_W'(1);
        CLS_ERR:  w_n_err  = w_n_err  + CNT_W'(1);
        default:  w_n_bad  = w_n_bad  + CNT_W'(1);
      endcase
    end
  end

  assign w_errored    = |w_err_mask;
  // The run length stops at the threshold so it can never wrap back below it.
  assign w_consec_inc = (r_consec == CONS_W'(ERR_THRESHOLD)) ? r_consec : r_consec + CONS_W'(1);
  assign w_hit        = (w_consec_inc == CONS_W'(ERR_THRESHOLD));

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [CNT_W-1:0]       b);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + (COUNT_WIDTH + 1)'(b);
    return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_data_cnt <= '0;
      r_ctrl_cnt <= '0;
      r_err_cnt  <= '0;
      r_bad_cnt  <= '0;
      r_lane_err <= '0;
    end else if (tx_en) begin
      r_data_cnt <= sat_add(r_data_cnt, w_n_data);
      r_ctrl_cnt <= sat_add(r_ctrl_cnt, w_n_ctrl);
      r_err_cnt  <= sat_add(r_err_cnt,  w_n_err);
      r_bad_cnt  <= sat_add(r_bad_cnt,  w_n_bad);
      r_lane_err <= w_err_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state  <= ST_IDLE;
      r_fault  <= 1'b0;
      r_consec <= '0;
    end else begin
      r_consec <= (tx_en && w_errored) ? w_consec_inc : '0;
      case (r_state)
        ST_IDLE: begin
          if (tx_en) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!tx_en) begin
            r_state <= ST_IDLE;
          end else if (w_errored && w_hit) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end
        end
        ST_FAULT: r_state <= ST_FAULT;
        default: begin
          r_state <= ST_IDLE;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

`ifdef MII_RX_CHECKER_TXER_CHECK_EN
  logic [COUNT_WIDTH-1:0] r_txer_cnt;
  logic                   w_any_err;

  always_comb begin
    w_any_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (w_class[i] == CLS_ERR) w_any_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_txer_cnt <= '0;
    end else if (tx_en && (tx_er != w_any_err)) begin
      r_txer_cnt <= sat_add(r_txer_cnt, CNT_W'(1));
    end
  end

  assign txer_mismatch_cnt = r_txer_cnt;
`else
  logic w_unused_tx_er;
  assign w_unused_tx_er    = tx_er;
  assign txer_mismatch_cnt = '0;
`endif

  assign data_cnt = r_data_cnt;
  assign ctrl_cnt = r_ctrl_cnt;
  assign err_cnt  = r_err_cnt;
  assign bad_cnt  = r_bad_cnt;
  assign lane_err = r_lane_err;
  assign state    = r_state;
  assign fault    = r_fault;

endmodule

// File: tb/tb_mii_rx_checker.sv
// Table-driven bench for mii_rx_checker; a second instance with 4-bit counters covers saturation.
module tb_mii_rx_checker;

  localparam logic [63:0] ALL_AA  = {8{8'hAA}};
  localparam logic [63:0] L03_CTL = {32'hAAAA_AAAA, 32'h5555_5555};
  localparam logic [63:0] L2_ERR  = 64'hAAAA_AAAA_AA55_AAAA;
  localparam logic [63:0] L0_BAD  = 64'hAAAA_AAAA_AAAA_AA12;
  localparam logic [63:0] MIXED   = 64'h55AA_AA12_AA55_55AA;
`ifdef MII_RX_CHECKER_TXER_CHECK_EN
  localparam int TXM = 1;
`else
  localparam int TXM = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, tx_en, tx_er, clr;
  logic [63:0] data_in;
  logic [7:0]  ctrl_in;

  logic [31:0] data_cnt, ctrl_cnt, err_cnt, bad_cnt, txer_cnt;
  logic [7:0]  lane_err;
  logic [1:0]  state;
  logic        fault;

  logic [3:0]  s_data_cnt, s_ctrl_cnt, s_err_cnt, s_bad_cnt, s_txer_cnt;
  logic [7:0]  s_lane_err;
  logic [1:0]  s_state;
  logic        s_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mii_rx_checker dut (
    .clk (clk), .rst (rst), .data_in (data_in), .ctrl_in (ctrl_in),
    .tx_en (tx_en), .tx_er (tx_er), .clr (clr),
    .data_cnt (data_cnt), .ctrl_cnt (ctrl_cnt), .err_cnt (err_cnt), .bad_cnt (bad_cnt),
    .txer_mismatch_cnt (txer_cnt), .lane_err (lane_err), .state (state), .fault (fault)
  );

  mii_rx_checker #(.COUNT_WIDTH (4)) dut_sat (
    .clk (clk), .rst (rst), .data_in (data_in), .ctrl_in (ctrl_in),
    .tx_en (tx_en), .tx_er (tx_er), .clr (clr),
    .data_cnt (s_data_cnt), .ctrl_cnt (s_ctrl_cnt), .err_cnt (s_err_cnt), .bad_cnt (s_bad_cnt),
    .txer_mismatch_cnt (s_txer_cnt), .lane_err (s_lane_err), .state (s_state), .fault (s_fault)
  );

  typedef struct {
    logic        en, er, cl;
    logic [63:0] d;
    logic [7:0]  c;
    int          e_data, e_ctrl, e_err, e_bad, e_txer;
    logic [7:0]  e_lerr;
    logic [1:0]  e_state;
    int          e_data2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic er, logic cl, logic [63:0] d, logic [7:0] c,
                              int ed, int ec, int ee, int eb, int et,
                              logic [7:0] el, logic [1:0] es, int ed2);
    vec_t v;
    v.en = en; v.er = er; v.cl = cl; v.d = d; v.c = c;
    v.e_data = ed; v.e_ctrl = ec; v.e_err = ee; v.e_bad = eb; v.e_txer = et;
    v.e_lerr = el; v.e_state = es; v.e_data2 = ed2;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic er, input logic cl,
                       input logic [63:0] d, input logic [7:0] c);
    tx_en = en; tx_er = er; clr = cl; data_in = d; ctrl_in = c;
  endtask

  initial begin
    // en er cl data     ctrl   data ctrl err bad txer     lerr   state  sat_data
    vecs.push_back(mk(1, 0, 0, ALL_AA,  8'h00,  8, 0, 0, 0, 0,     8'h00, 2'd1,  8));
    vecs.push_back(mk(1, 0, 0, L03_CTL, 8'h0F, 12, 4, 0, 0, 0,     8'h00, 2'd1, 12));
    vecs.push_back(mk(1, 1, 0, L2_ERR,  8'h00, 19, 4, 1, 0, 0,     8'h04, 2'd1, 15));
    vecs.push_back(mk(1, 0, 0, L2_ERR,  8'h00, 26, 4, 2, 0, TXM,   8'h04, 2'd1, 15));
    vecs.push_back(mk(0, 0, 0, 64'h0,   8'h00, 26, 4, 2, 0, TXM,   8'h04, 2'd0, 15));
    vecs.push_back(mk(1, 1, 0, ALL_AA,  8'h00, 34, 4, 2, 0, 2*TXM, 8'h00, 2'd1, 15));
    vecs.push_back(mk(1, 0, 1, ALL_AA,  8'h00,  0, 0, 0, 0, 0,     8'h00, 2'd0,  0));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00,  7, 0, 0, 1, 0,     8'h01, 2'd1,  7));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00, 14, 0, 0, 2, 0,     8'h01, 2'd1, 14));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00, 21, 0, 0, 3, 0,     8'h01, 2'd1, 15));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00, 28, 0, 0, 4, 0,     8'h01, 2'd2, 15));
    vecs.push_back(mk(0, 0, 0, 64'h0,   8'h00, 28, 0, 0, 4, 0,     8'h01, 2'd2, 15));
    vecs.push_back(mk(1, 0, 0, ALL_AA,  8'h00, 36, 0, 0, 4, 0,     8'h00, 2'd2, 15));
    vecs.push_back(mk(0, 0, 1, 64'h0,   8'h00,  0, 0, 0, 0, 0,     8'h00, 2'd0,  0));
    vecs.push_back(mk(1, 0, 0, ALL_AA,  8'h00,  8, 0, 0, 0, 0,     8'h00, 2'd1,  8));
    vecs.push_back(mk(1, 0, 0, ALL_AA,  8'h00, 16, 0, 0, 0, 0,     8'h00, 2'd1, 15));
    vecs.push_back(mk(1, 0, 1, ALL_AA,  8'h00,  0, 0, 0, 0, 0,     8'h00, 2'd0,  0));
    vecs.push_back(mk(1, 1, 0, MIXED,   8'h9A,  3, 2, 1, 2, 0,     8'h1C, 2'd1,  3));
    vecs.push_back(mk(1, 0, 0, ALL_AA,  8'h00, 11, 2, 1, 2, 0,     8'h00, 2'd1, 11));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00, 18, 2, 1, 3, 0,     8'h01, 2'd1, 15));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00, 25, 2, 1, 4, 0,     8'h01, 2'd1, 15));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00, 32, 2, 1, 5, 0,     8'h01, 2'd1, 15));
    vecs.push_back(mk(1, 0, 0, ALL_AA,  8'h00, 40, 2, 1, 5, 0,     8'h00, 2'd1, 15));
    vecs.push_back(mk(1, 0, 0, L0_BAD,  8'h00, 47, 2, 1, 6, 0,     8'h01, 2'd1, 15));

    // Reset with an active data cycle present: nothing may be counted.
    rst = 1'b1;
    drive(1, 0, 0, ALL_AA, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst data_cnt", data_cnt, 0);
    check("rst ctrl_cnt", ctrl_cnt, 0);
    check("rst err_cnt",  err_cnt,  0);
    check("rst bad_cnt",  bad_cnt,  0);
    check("rst txer_cnt", txer_cnt, 0);
    check("rst lane_err", lane_err, 0);
    check("rst state",    state,    0);
    check("rst fault",    fault,    0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].er, vecs[i].cl, vecs[i].d, vecs[i].c);
      @(posedge clk);
      #1;
      check($sformatf("v%0d data_cnt", i), data_cnt, vecs[i].e_data);
      check($sformatf("v%0d ctrl_cnt", i), ctrl_cnt, vecs[i].e_ctrl);
      check($sformatf("v%0d err_cnt",  i), err_cnt,  vecs[i].e_err);
      check($sformatf("v%0d bad_cnt",  i), bad_cnt,  vecs[i].e_bad);
      check($sformatf("v%0d txer_cnt", i), txer_cnt, vecs[i].e_txer);
      check($sformatf("v%0d lane_err", i), lane_err, vecs[i].e_lerr);
      check($sformatf("v%0d state",    i), state,    vecs[i].e_state);
      check($sformatf("v%0d fault",    i), fault,    vecs[i].e_state == 2'd2);
      check($sformatf("v%0d sat data", i), s_data_cnt, vecs[i].e_data2);
      @(negedge clk);
    end

    // rst and clr together with active data: rst wins, nothing counted.
    rst = 1'b1;
    drive(1, 1, 1, L0_BAD, 8'h00);
    @(posedge clk);
    #1;
    check("rst+clr data_cnt", data_cnt, 0);
    check("rst+clr bad_cnt",  bad_cnt,  0);
    check("rst+clr lane_err", lane_err, 0);
    check("rst+clr state",    state,    0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, ALL_AA, 8'h00);
    @(posedge clk);
    #1;
    check("post-rst data_cnt", data_cnt, 8);
    check("post-rst state",    state,    1);
    @(negedge clk);
    drive(0, 0, 0, 64'h0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_rx_checker.md
MII_RX_CHECKER -- requirements
Module: mii_rx_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, lane data width in bits (multiple of 8; LANES = DATA_WIDTH/8).
REQ-002 SHALL have parameter DATA_CHAR_PATTERN, default 8'hAA, expected data byte.
REQ-003 SHALL have parameter CTRL_CHAR_PATTERN, default 8'h55, expected control byte.
REQ-004 SHALL have parameter COUNT_WIDTH, default 32, statistics counter width.
REQ-005 SHALL have parameter ERR_THRESHOLD, default 4, consecutive errored active cycles that trigger FAULT.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port data_in, input, DATA_WIDTH, MII data; byte i is lane i.
REQ-009 SHALL have port ctrl_in, input, LANES, per-lane control flag (1 = control character).
REQ-010 SHALL have port tx_en, input, 1, lanes valid this cycle.
REQ-011 SHALL have port tx_er, input, 1, upstream error flag for the same cycle as the data.
REQ-012 SHALL have port clr, input, 1, synchronous clear of counters and FAULT.
REQ-013 SHALL have ports data_cnt, ctrl_cnt, err_cnt, bad_cnt, output, COUNT_WIDTH each, per-class lane counts.
REQ-014 SHALL have port txer_mismatch_cnt, output, COUNT_WIDTH, cycles where tx_er disagrees with the lane contents.
REQ-015 SHALL have port lane_err, output, LANES, registered per-lane error-or-bad mask of the last active cycle.
REQ-016 SHALL have port state, output, 2, current FSM state; port fault, output, 1, high while state is FAULT.

Function
REQ-017 SHALL classify each lane while tx_en=1: ctrl=1 and byte=CTRL_CHAR_PATTERN is CTRL; ctrl=0 and byte=DATA_CHAR_PATTERN is DATA; ctrl=0 and byte=~DATA_CHAR_PATTERN is ERR; anything else is BAD.
REQ-018 SHALL add, on the clock edge after an active cycle, the number of lanes of each class (0..LANES) to the matching counter, so outputs have 1-cycle latency.
REQ-019 SHALL saturate every counter at all-ones; an addition that would overflow SHALL yield all-ones.
REQ-020 SHALL leave counters and lane_err unchanged while tx_en=0.
REQ-021 SHALL increment txer_mismatch_cnt by 1 when tx_en=1 and tx_er differs from "any lane is ERR".
REQ-022 SHALL run the FSM IDLE(0) -> RUN(1) on tx_en=1; RUN -> IDLE on tx_en=0; RUN -> FAULT(2) when the consecutive-errored-cycle count reaches ERR_THRESHOLD; FAULT -> IDLE only on clr.
REQ-023 SHALL count an active cycle as errored if any lane is ERR or BAD, and SHALL reset the consecutive count to 0 on a clean active cycle or on tx_en=0.
REQ-024 SHALL keep counting statistics in FAULT while tx_en=1.
REQ-025 SHALL give clr priority over same-cycle data: counters, lane_err and consecutive count go to 0, state goes to IDLE, and that cycle's lanes are not counted.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set all counters to 0, lane_err to 0, state to IDLE, fault to 0, and the consecutive count to 0; rst SHALL override clr.

Configuration
REQ-027 SHALL, with MII_RX_CHECKER_TXER_CHECK_EN defined, implement REQ-021; without it, txer_mismatch_cnt SHALL be held at 0 and the comparison logic SHALL be absent.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/RUN/FAULT), the lane class enum (DATA/CTRL/ERR/BAD) and the default patterns in the shared package mii_pkg.
REQ-029 SHALL implement per-lane classification in sub-module mii_lane_classify (combinational, one byte plus ctrl bit in, class out), instantiated LANES times.

Verification
REQ-030 SHALL verify: rst then 1 cycle tx_en=1, all lanes 8'hAA with ctrl=0 -> next cycle data_cnt=8, other counts 0, state=RUN.
REQ-031 SHALL verify: lanes 0-3 = 8'h55 with ctrl=1, lanes 4-7 = 8'hAA, tx_er=0 -> ctrl_cnt=4, data_cnt=4, lane_err=0.
REQ-032 SHALL verify: lane 2 = 8'h55 with tx_er=1, rest 8'hAA -> err_cnt=1, lane_err=8'h04; with the macro defined txer_mismatch_cnt=0, then tx_er=0 with the same data -> txer_mismatch_cnt=1.
REQ-033 SHALL verify: 4 consecutive cycles with lane 0 = 8'h12 and ctrl=0 -> bad_cnt=4, state=FAULT, fault=1; tx_en=0 keeps FAULT; clr -> IDLE, all counters 0.
REQ-034 SHALL verify: COUNT_WIDTH=4, 2 cycles of 8 DATA lanes -> data_cnt=15 (saturated); clr asserted alongside a data cycle -> data_cnt=0.
